demux1xn_hot_buffered: RTL and testbench

Registered, parametrised 1-to-N one-hot demultiplexer with per-output valid/ready handshake, optional multicast and illegal-select accounting. It sits in the access-control path between a single GLB/NoC source and N consumer ports (PE clusters, scratchpad writers). It replaces fixed-width combinational one-hot demuxes wherever the destination can stall or several destinations must receive the same word.

---
 rtl/demux1xn_hot_buffered.sv | 138 +++++++++++++
 tb/tb_demux1xn_hot_buffered.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1xn_hot_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : demux1xn_hot_buffered
//  Purpose  : Registered 1-to-N one-hot demultiplexer. Each output channel has
//             its own holding register with a valid/ready handshake. The
//             block can optionally multicast one word to several channels.
//             Illegal selects are dropped and counted.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             in_valid/in_ready - source handshake
//             in_sel            - destination mask (one-hot, or multi-hot
//                                 when multicast is enabled)
//             in_data           - payload
//             out_valid/out_ready - per-channel consumer handshake
//             out_data          - channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//             clear_err         - clears err_flag and drop_count
//             err_flag          - sticky illegal-select indicator
//             drop_count        - saturating count of dropped words
//  Revision : 1.0 - initial release
// ============================================================================
module demux1xn_hot_buffered #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned NUM_OUT         = 4,
    parameter int unsigned ALLOW_MULTICAST = 0,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_OUT-1:0]            in_sel,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    input  logic                          clear_err,
    output logic                          err_flag,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    localparam logic [NUM_OUT-1:0]   c_SEL_ONE = NUM_OUT'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic                 c_MCAST   = (ALLOW_MULTICAST != 0);

    logic [NUM_OUT-1:0]            out_valid_q,  out_valid_d;
    logic [NUM_OUT*DATA_WIDTH-1:0] out_data_q,   out_data_d;
    logic                          err_flag_q,   err_flag_d;
    logic [CNT_WIDTH-1:0]          drop_count_q, drop_count_d;

    logic                          w_sel_nonzero;
    logic                          w_sel_multi;
    logic                          w_legal;
    logic [NUM_OUT-1:0]            w_can_take;
    logic                          w_all_take;
    logic                          w_xfer;
    logic                          w_drop;
    logic [NUM_OUT-1:0]            w_load;
    logic [CNT_WIDTH-1:0]          w_cnt_base;

    // ------------------------------------------------------------------
    // Select decode and source-side handshake
    // ------------------------------------------------------------------
    // Clearing the lowest set bit leaves something only if more than one
    // bit was set.
    assign w_sel_nonzero = |in_sel;
    assign w_sel_multi   = |(in_sel & (in_sel - c_SEL_ONE));
    assign w_legal       = w_sel_nonzero && (!w_sel_multi || c_MCAST);

    // A channel can take a word if it is empty or being drained this cycle.
    assign w_can_take    = ~out_valid_q | out_ready;
    // Unselected channels are masked to 1 so only selected ones gate ready.
    assign w_all_take    = &(w_can_take | ~in_sel);

    // Illegal selects are always accepted so the source never deadlocks.
    assign in_ready      = w_legal ? w_all_take : 1'b1;

    assign w_xfer        = in_valid && w_legal && w_all_take;
    assign w_drop        = in_valid && !w_legal;
    assign w_load        = w_xfer ? in_sel : '0;

    // ------------------------------------------------------------------
    // Per-channel holding registers: load beats pop, so a same-cycle pop
    // and load keeps the channel full with the new word (no bubble).
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_load[i]) begin
                out_valid_d[i]                           = 1'b1;
                out_data_d[i*DATA_WIDTH +: DATA_WIDTH]   = in_data;
            end else if (out_valid_q[i] && out_ready[i]) begin
                out_valid_d[i]                           = 1'b0;
                out_data_d[i*DATA_WIDTH +: DATA_WIDTH]   = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error accounting: a drop in the same cycle as clear_err wins, so the
    // counter restarts from zero and then counts that drop.
    // ------------------------------------------------------------------
    assign w_cnt_base = clear_err ? '0 : drop_count_q;

    always_comb begin
        err_flag_d   = err_flag_q;
        drop_count_d = drop_count_q;
        if (w_drop) begin
            err_flag_d   = 1'b1;
            drop_count_d = (w_cnt_base == c_CNT_MAX) ? w_cnt_base
                                                     : w_cnt_base + c_CNT_ONE;
        end else if (clear_err) begin
            err_flag_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= '0;
            out_data_q   <= '0;
            err_flag_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            err_flag_q   <= err_flag_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign err_flag   = err_flag_q;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_demux1xn_hot_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux1xn_hot_buffered
//  Purpose  : Self-checking bench. DUT "a" is unicast-only with a 2-bit drop
//             counter; DUT "b" allows multicast with an 8-bit counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux1xn_hot_buffered;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_in_valid, a_in_ready, a_clear, a_err;
    logic [3:0]  a_in_sel, a_out_valid, a_out_ready;
    logic [15:0] a_in_data;
    logic [63:0] a_out_data;
    logic [1:0]  a_drop_count;

    logic        b_in_valid, b_in_ready, b_clear, b_err;
    logic [3:0]  b_in_sel, b_out_valid, b_out_ready;
    logic [15:0] b_in_data;
    logic [63:0] b_out_data;
    logic [7:0]  b_drop_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: [dut][channel]
    logic        mv [2][4];
    logic [15:0] md [2][4];
    logic        merr [2];
    int          mcnt [2];

    always #5 clk = ~clk;

    demux1xn_hot_buffered #(
        .DATA_WIDTH(16), .NUM_OUT(4), .ALLOW_MULTICAST(0), .CNT_WIDTH(2)
    ) u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .clear_err(a_clear), .err_flag(a_err),
        .drop_count(a_drop_count)
    );

    demux1xn_hot_buffered #(
        .DATA_WIDTH(16), .NUM_OUT(4), .ALLOW_MULTICAST(1), .CNT_WIDTH(8)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .clear_err(b_clear), .err_flag(b_err),
        .drop_count(b_drop_count)
    );

    task automatic idle_inputs();
        a_in_valid = 0; a_in_sel = 0; a_in_data = 0; a_out_ready = 4'hF; a_clear = 0;
        b_in_valid = 0; b_in_sel = 0; b_in_data = 0; b_out_ready = 4'hF; b_clear = 0;
    endtask

    // ---------------- reference model (spec-level rules) ----------------
    function automatic logic model_ready(int d, logic [3:0] sel, logic [3:0] ord);
        bit legal;
        logic r;
        legal = (sel != 0) && ($countones(sel) == 1 || d == 1);
        r = 1'b1;
        if (legal)
            for (int i = 0; i < 4; i++)
                if (sel[i] && mv[d][i] && !ord[i]) r = 1'b0;
        return r;
    endfunction

    task automatic model_step(int d, logic v, logic [3:0] sel, logic [15:0] data,
                              logic [3:0] ord, logic clr);
        bit legal;
        bit xfer;
        int cmax;
        cmax  = (d == 0) ? 3 : 255;
        legal = (sel != 0) && ($countones(sel) == 1 || d == 1);
        xfer  = v && legal && model_ready(d, sel, ord);
        for (int i = 0; i < 4; i++) begin
            if (xfer && sel[i]) begin
                mv[d][i] = 1'b1; md[d][i] = data;
            end else if (mv[d][i] && ord[i]) begin
                mv[d][i] = 1'b0; md[d][i] = 16'h0;
            end
        end
        if (v && !legal) begin
            if (clr) mcnt[d] = 0;
            merr[d] = 1'b1;
            if (mcnt[d] < cmax) mcnt[d] = mcnt[d] + 1;
        end else if (clr) begin
            merr[d] = 1'b0; mcnt[d] = 0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin mv[d][i] = 0; md[d][i] = 0; end
            merr[d] = 0; mcnt[d] = 0;
        end
    endtask

    // ---------------------------- tests ----------------------------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_vec += 8;
        if (a_out_valid !== 4'h0) begin n_err++; $display("FAIL reset_a_valid got %h want 0", a_out_valid); end
        if (a_out_data !== 64'h0) begin n_err++; $display("FAIL reset_a_data got %h want 0", a_out_data); end
        if (a_err !== 1'b0) begin n_err++; $display("FAIL reset_a_err got %b want 0", a_err); end
        if (a_drop_count !== 2'd0) begin n_err++; $display("FAIL reset_a_cnt got %0d want 0", a_drop_count); end
        if (b_out_valid !== 4'h0) begin n_err++; $display("FAIL reset_b_valid got %h want 0", b_out_valid); end
        if (b_out_data !== 64'h0) begin n_err++; $display("FAIL reset_b_data got %h want 0", b_out_data); end
        if (b_err !== 1'b0) begin n_err++; $display("FAIL reset_b_err got %b want 0", b_err); end
        if (b_drop_count !== 8'd0) begin n_err++; $display("FAIL reset_b_cnt got %0d want 0", b_drop_count); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        a_out_ready = 4'hF; a_in_valid = 1; a_in_sel = 4'b0100; a_in_data = 16'hABCD;
        #1; n_vec++;
        if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got %b want 1", a_in_ready); end
        @(posedge clk); #1; n_vec += 2;
        if (a_out_valid !== 4'b0100) begin n_err++; $display("FAIL single_valid got %h want 4", a_out_valid); end
        if (a_out_data !== 64'h0000_ABCD_0000_0000) begin n_err++; $display("FAIL single_data got %h want 0000abcd00000000", a_out_data); end
        @(negedge clk); a_in_valid = 0;
        @(posedge clk); #1; n_vec += 2;
        if (a_out_valid !== 4'h0) begin n_err++; $display("FAIL single_pop_valid got %h want 0", a_out_valid); end
        if (a_out_data !== 64'h0) begin n_err++; $display("FAIL single_pop_data got %h want 0", a_out_data); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        a_out_ready = 4'b1101; a_in_valid = 1; a_in_sel = 4'b0010; a_in_data = 16'h0001;
        #1; n_vec++;
        if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_ready got %b want 1", a_in_ready); end
        @(posedge clk); #1; n_vec++;
        if (a_out_data[31:16] !== 16'h0001) begin n_err++; $display("FAIL bp_first_data got %h want 0001", a_out_data[31:16]); end
        @(negedge clk); a_in_data = 16'h0002;
        #1; n_vec++;
        if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready got %b want 0", a_in_ready); end
        @(posedge clk); #1; n_vec += 2;
        if (a_out_valid !== 4'b0010) begin n_err++; $display("FAIL bp_hold_valid got %h want 2", a_out_valid); end
        if (a_out_data[31:16] !== 16'h0001) begin n_err++; $display("FAIL bp_hold_data got %h want 0001", a_out_data[31:16]); end
        @(negedge clk); a_out_ready = 4'hF;
        #1; n_vec++;
        if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", a_in_ready); end
        @(posedge clk); #1; n_vec += 2;
        if (a_out_valid !== 4'b0010) begin n_err++; $display("FAIL bp_nobubble_valid got %h want 2", a_out_valid); end
        if (a_out_data !== 64'h0000_0000_0002_0000) begin n_err++; $display("FAIL bp_nobubble_data got %h want 0000000000020000", a_out_data); end
        @(negedge clk); a_in_valid = 0;
        @(posedge clk);
    endtask

    task automatic test_multicast();
        @(negedge clk);
        b_out_ready = 4'b0111; b_in_valid = 1; b_in_sel = 4'b1000; b_in_data = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        b_in_sel = 4'b1011; b_in_data = 16'h5A5A;
        #1; n_vec++;
        if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL mc_blocked_ready got %b want 0", b_in_ready); end
        @(posedge clk); #1; n_vec += 2;
        if (b_out_valid !== 4'b1000) begin n_err++; $display("FAIL mc_blocked_valid got %h want 8", b_out_valid); end
        if (b_out_data !== 64'h1111_0000_0000_0000) begin n_err++; $display("FAIL mc_blocked_data got %h want 1111000000000000", b_out_data); end
        @(negedge clk); b_out_ready = 4'hF;
        #1; n_vec++;
        if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL mc_release_ready got %b want 1", b_in_ready); end
        @(posedge clk); #1; n_vec += 2;
        if (b_out_valid !== 4'b1011) begin n_err++; $display("FAIL mc_valid got %h want b", b_out_valid); end
        if (b_out_data !== 64'h5A5A_0000_5A5A_5A5A) begin n_err++; $display("FAIL mc_data got %h want 5a5a00005a5a5a5a", b_out_data); end
        @(negedge clk); b_in_valid = 0;
        @(posedge clk);
    endtask

    task automatic test_illegal_saturation();
        @(negedge clk);
        a_out_ready = 4'hF; a_in_valid = 1; a_in_sel = 4'b0000; a_in_data = 16'hDEAD;
        #1; n_vec++;
        if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL ill_zero_ready got %b want 1", a_in_ready); end
        @(negedge clk); a_in_sel = 4'b0110;
        #1; n_vec++;
        if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL ill_multi_ready got %b want 1", a_in_ready); end
        @(posedge clk); #1; n_vec += 3;
        if (a_out_valid !== 4'h0) begin n_err++; $display("FAIL ill_valid got %h want 0", a_out_valid); end
        if (a_err !== 1'b1) begin n_err++; $display("FAIL ill_err got %b want 1", a_err); end
        if (a_drop_count !== 2'd2) begin n_err++; $display("FAIL ill_cnt got %0d want 2", a_drop_count); end
        // three more drops: 5 total saturates a 2-bit counter at 3
        repeat (3) @(posedge clk);
        #1; n_vec++;
        if (a_drop_count !== 2'd3) begin n_err++; $display("FAIL sat_cnt got %0d want 3", a_drop_count); end
        @(negedge clk); a_clear = 1; a_in_sel = 4'b0000;
        @(posedge clk); #1; n_vec += 2;
        if (a_drop_count !== 2'd1) begin n_err++; $display("FAIL clr_drop_cnt got %0d want 1", a_drop_count); end
        if (a_err !== 1'b1) begin n_err++; $display("FAIL clr_drop_err got %b want 1", a_err); end
        @(negedge clk); a_in_valid = 0;
        @(posedge clk); #1; n_vec += 2;
        if (a_drop_count !== 2'd0) begin n_err++; $display("FAIL clr_cnt got %0d want 0", a_drop_count); end
        if (a_err !== 1'b0) begin n_err++; $display("FAIL clr_err got %b want 0", a_err); end
        @(negedge clk); a_clear = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); a_out_ready = 4'h0; a_in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            a_in_sel = 4'(1 << k); a_in_data = 16'(16'h10 + k);
            @(negedge clk);
        end
        a_in_sel = 4'b0000;
        @(posedge clk); #1; n_vec += 2;
        if (a_out_valid !== 4'hF) begin n_err++; $display("FAIL mid_full_valid got %h want f", a_out_valid); end
        if (a_out_data !== 64'h0013_0012_0011_0010) begin n_err++; $display("FAIL mid_full_data got %h want 0013001200110010", a_out_data); end
        @(negedge clk); a_in_valid = 0; reset = 1;
        @(posedge clk); #1; n_vec += 4;
        if (a_out_valid !== 4'h0) begin n_err++; $display("FAIL mid_rst_valid got %h want 0", a_out_valid); end
        if (a_out_data !== 64'h0) begin n_err++; $display("FAIL mid_rst_data got %h want 0", a_out_data); end
        if (a_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_err got %b want 0", a_err); end
        if (a_drop_count !== 2'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d want 0", a_drop_count); end
        @(negedge clk); reset = 0; idle_inputs();
    endtask

    task automatic test_random();
        logic [63:0] exp_d;
        @(negedge clk); idle_inputs(); reset = 1;
        @(posedge clk);
        model_reset();
        @(negedge clk); reset = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            a_in_valid = 1'($urandom); b_in_valid = 1'($urandom);
            a_in_sel = ($urandom_range(9) < 7) ? 4'(1 << $urandom_range(3)) : 4'($urandom);
            b_in_sel = ($urandom_range(9) < 5) ? 4'(1 << $urandom_range(3)) : 4'($urandom);
            a_in_data = 16'($urandom); b_in_data = 16'($urandom);
            a_out_ready = 4'($urandom); b_out_ready = 4'($urandom);
            a_clear = ($urandom_range(15) == 0); b_clear = ($urandom_range(15) == 0);
            #1; n_vec += 2;
            if (a_in_ready !== model_ready(0, a_in_sel, a_out_ready)) begin
                n_err++; $display("FAIL rnd_a_ready cyc %0d got %b want %b", cyc, a_in_ready, model_ready(0, a_in_sel, a_out_ready));
            end
            if (b_in_ready !== model_ready(1, b_in_sel, b_out_ready)) begin
                n_err++; $display("FAIL rnd_b_ready cyc %0d got %b want %b", cyc, b_in_ready, model_ready(1, b_in_sel, b_out_ready));
            end
            model_step(0, a_in_valid, a_in_sel, a_in_data, a_out_ready, a_clear);
            model_step(1, b_in_valid, b_in_sel, b_in_data, b_out_ready, b_clear);
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                logic [3:0] ev;
                for (int i = 0; i < 4; i++) begin ev[i] = mv[d][i]; exp_d[i*16 +: 16] = md[d][i]; end
                n_vec += 4;
                if ((d == 0 ? a_out_valid : b_out_valid) !== ev) begin
                    n_err++; $display("FAIL rnd_valid dut %0d cyc %0d got %h want %h", d, cyc, (d == 0 ? a_out_valid : b_out_valid), ev);
                end
                if ((d == 0 ? a_out_data : b_out_data) !== exp_d) begin
                    n_err++; $display("FAIL rnd_data dut %0d cyc %0d got %h want %h", d, cyc, (d == 0 ? a_out_data : b_out_data), exp_d);
                end
                if ((d == 0 ? a_err : b_err) !== merr[d]) begin
                    n_err++; $display("FAIL rnd_err dut %0d cyc %0d got %b want %b", d, cyc, (d == 0 ? a_err : b_err), merr[d]);
                end
                if ((d == 0 ? int'(a_drop_count) : int'(b_drop_count)) != mcnt[d]) begin
                    n_err++; $display("FAIL rnd_cnt dut %0d cyc %0d got %0d want %0d", d, cyc, (d == 0 ? int'(a_drop_count) : int'(b_drop_count)), mcnt[d]);
                end
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_multicast();
        test_illegal_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
